// File: rtl/seg_code_to_num_pkg.sv
// Shared definitions for the seven-segment loopback decoder and the matching
// number-to-segment encoder: segment patterns, frame size and FSM state type.
package seg_code_to_num_pkg;

  // Digits per frame (hundreds, tens, ones)
  localparam int DIGITS = 3;

  // Digit counter width and the index of the last digit in a frame
  localparam int CNT_W = 2;
  localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(DIGITS - 1);

  // Segment bit layout: bit7=a ... bit1=g, bit0=dp
  localparam int SEG_DP_BIT = 0;

  // Segment patterns with dp cleared
  localparam logic [7:0] SEG_0     = 8'hfc;
  localparam logic [7:0] SEG_1     = 8'h60;
  localparam logic [7:0] SEG_2     = 8'hda;
  localparam logic [7:0] SEG_3     = 8'hf2;
  localparam logic [7:0] SEG_4     = 8'h66;
  localparam logic [7:0] SEG_5     = 8'hb6;
  localparam logic [7:0] SEG_6     = 8'hbe;
  localparam logic [7:0] SEG_7     = 8'he0;
  localparam logic [7:0] SEG_8     = 8'hfe;
  localparam logic [7:0] SEG_9     = 8'hf6;
  localparam logic [7:0] SEG_BLANK = 8'h00;

  // Decoder FSM: gathering digits, or holding a finished frame
  typedef enum logic {
    COLLECT = 1'b0,
    DONE    = 1'b1
  } state_t;

endpackage

// File: rtl/seg_digit_lookup.sv
// Combinational reverse lookup from a seven-segment code to a decimal digit.
// The dp bit never takes part in the match.
module seg_digit_lookup
  import seg_code_to_num_pkg::*;
(
  input  logic [7:0] code,
  output logic       is_blank,
  output logic       is_valid,
  output logic [3:0] digit
);

  // dp is deliberately ignored; keep it visibly unused
  logic unused_dp;
  assign unused_dp = code[SEG_DP_BIT];

  // Match segments a..g against the digit table; anything unknown is invalid
  always_comb begin
    is_blank = 1'b0;
    is_valid = 1'b1;
    digit    = 4'd0;
    case (code[7:1])
      SEG_0[7:1]:     digit = 4'd0;
      SEG_1[7:1]:     digit = 4'd1;
      SEG_2[7:1]:     digit = 4'd2;
      SEG_3[7:1]:     digit = 4'd3;
      SEG_4[7:1]:     digit = 4'd4;
      SEG_5[7:1]:     digit = 4'd5;
      SEG_6[7:1]:     digit = 4'd6;
      SEG_7[7:1]:     digit = 4'd7;
      SEG_8[7:1]:     digit = 4'd8;
      SEG_9[7:1]:     digit = 4'd9;
      SEG_BLANK[7:1]: begin
        is_blank = 1'b1;
        is_valid = 1'b0;
      end
      default:        is_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_code_to_num.sv
// Loopback decoder: collects three seven-segment codes (MSD first) and
// rebuilds the displayed number as BCD and binary, flagging bad frames.
module seg_code_to_num
  import seg_code_to_num_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic [7:0]  seg_code,
  input  logic        seg_valid,
  output logic        seg_ready,
  output logic [11:0] bcd,
  output logic [9:0]  bin,
  output logic        err,
  output logic        out_valid,
  input  logic        out_ready
);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [9:0]       acc;
  logic [9:0]       acc_next;
  logic             seen;
  logic             is_blank;
  logic             is_valid;
  logic [3:0]       digit;
  logic [3:0]       d;
  logic             code_err;
  logic             accept;
  logic             last_digit;
  logic             frame_taken;

  seg_digit_lookup u_lookup (
    .code     (seg_code),
    .is_blank (is_blank),
    .is_valid (is_valid),
    .digit    (digit)
  );

  // Blanks and unknown codes contribute a zero digit; only leading blanks are clean
  assign d           = is_valid ? digit : 4'd0;
  assign code_err    = !is_valid && !(is_blank && !seen);
  assign acc_next    = (acc << 3) + (acc << 1) + {6'd0, d};
  assign accept      = seg_valid && seg_ready;
  assign last_digit  = (cnt == LAST_DIGIT);
  assign frame_taken = out_valid && out_ready;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= COLLECT;
    end else begin
      state <= state_next;
    end
  end

  // Next state: third accept finishes the frame, out handshake or clr restarts
  always_comb begin
    state_next = state;
    if (clr) begin
      state_next = COLLECT;
    end else begin
      case (state)
        COLLECT: if (accept && last_digit) state_next = DONE;
        DONE:    if (frame_taken)          state_next = COLLECT;
        default: state_next = COLLECT;
      endcase
    end
  end

  // Handshake outputs follow the state directly
  always_comb begin
    seg_ready = (state == COLLECT);
    out_valid = (state == DONE);
  end

  // Digit counter, accumulator, BCD shift register and per-frame flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt  <= '0;
      acc  <= '0;
      bcd  <= '0;
      bin  <= '0;
      err  <= 1'b0;
      seen <= 1'b0;
    end else if (clr) begin
      cnt  <= '0;
      acc  <= '0;
      bcd  <= '0;
      bin  <= '0;
      err  <= 1'b0;
      seen <= 1'b0;
    end else if (state == COLLECT && accept) begin
      bcd  <= {bcd[7:0], d};
      acc  <= acc_next;
      err  <= err | code_err;
      seen <= seen | !is_blank;
      if (last_digit) begin
        cnt <= '0;
        bin <= acc_next;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else if (state == DONE && frame_taken) begin
      acc  <= '0;
      bcd  <= '0;
      err  <= 1'b0;
      seen <= 1'b0;
    end
  end

endmodule

// File: doc/seg_code_to_num.md
# seg_code_to_num

Sequential decoder that turns a stream of seven-segment codes back into a number in 0-999. It takes one 8-bit segment code per handshake, most-significant digit first, and assembles three digits into a 12-bit BCD value and a 10-bit binary value. It sits on the display side of the calculator as a loopback/self-check path, so the team can confirm that segment patterns driven to the digits decode to the intended operand or result.

## Interface
- DIGITS, 3: digits per frame; fixed at 3 for this design.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous frame abort; discards any partial frame.
- seg_code  in  8  segment code, bit7=a … bit1=g, bit0=dp.
- seg_valid  in  1  seg_code is valid this cycle.
- seg_ready  out  1  decoder can accept a code.
- bcd  out  12  [11:8] hundreds, [7:4] tens, [3:0] ones.
- bin  out  10  binary value, 0-999.
- err  out  1  frame contained an invalid or misplaced code.
- out_valid  out  1  bcd/bin/err hold a complete frame.
- out_ready  in  1  consumer accepts the frame.

## Operation
- Codes: 0=fc, 1=60, 2=da, 3=f2, 4=66, 5=b6, 6=be, 7=e0, 8=fe, 9=f6, blank=00.
- dp (bit0) is ignored for matching: codes are compared on bits [7:1].
- States:
  - COLLECT (digit counter 0..2, seg_ready=1).
  - DONE (seg_ready=0, out_valid=1).
- Accept: a code is taken when seg_valid && seg_ready at a clk edge.
- Digit d is shifted into bcd from the right: bcd <= {bcd[7:0], d}.
- acc <= acc*10 + d. Compute acc*10 as (acc<<3)+(acc<<1) in 10 bits; acc never exceeds 999.
- Leading blanks: a blank before any non-blank digit decodes as 0 and does not flag an error.
- A blank after a non-blank digit decodes as 0 and sets err. The "seen non-blank" flag is per frame.
- Any other code not in the table decodes as 0 and sets err. err is sticky for the frame.
- The third accept moves COLLECT→DONE. The counter clears and bin takes the final acc.
- DONE→COLLECT on out_valid && out_ready. acc, err, the seen flag and bcd clear for the next frame.
- clr: in any state, go to COLLECT with counter, acc, bcd, bin, err and seen cleared, and out_valid=0. clr overrides a simultaneous accept or out handshake.

## Timing
- Reset values: seg_ready=1, out_valid=0, bcd=0, bin=0, err=0. State is COLLECT, counter 0.
- Reset applies immediately on rst low, including mid-frame or in DONE.
- Latency: out_valid rises on the edge that accepts the third code. It is visible in the cycle after that handshake.
- Back-to-back codes are accepted on consecutive cycles in COLLECT.
- In DONE, seg_ready=0. Codes presented then are not accepted and must be held by the sender.
- out_valid, bcd, bin and err stay stable until the out handshake.
- seg_ready returns to 1 in the cycle after the out handshake. There is no same-cycle accept of a new code during the DONE→COLLECT transition.
- seg_valid is ignored while seg_ready=0.

## Structure
- Shared package: segment code constants SEG_0…SEG_9 and SEG_BLANK, the DP bit index, and the state type.
- The num-to-code encoder uses the same constants.
- Sub-module seg_digit_lookup: combinational 8-bit code → {is_blank, is_valid, digit[3:0]}.
- The FSM, counter and accumulator live in seg_code_to_num.

## Test plan
- Reset mid-frame: send f2, de-assert rst for 1 cycle, then send 60, fc, f6 → out_valid, bcd=0x109, bin=109, err=0.
- Normal frame: send b6, e0, 66, hold out_ready=0 for 5 cycles.
  - Expect bcd=0x574, bin=574, err=0.
  - Outputs stable throughout; seg_ready=0 throughout.
- Leading blanks and dp: send 00, 00, 61 → bcd=0x001, bin=1, err=0.
- Misplaced blank and bad code:
  - 60, 00, fe → bcd=0x108, bin=108, err=1.
  - 60, 12, fe (next frame) → bcd=0x108, bin=108, err=1.
- Back-to-back frames: stream f6, f6, f6, then 60, fc, fc with out_ready=1 and seg_valid=1.
  - Frames read 999 then 100.
  - Exactly one bubble cycle on seg_ready between them.
- clr in both states:
  - clr after two codes, then fc, fc, da → bcd=0x002.
  - clr in DONE → out_valid drops the next cycle and no frame is delivered.
